// File: rtl/riscv_defines.sv
// Shared RISC-V constants and the fetch buffer entry layout.
package riscv_defines;

   localparam int unsigned XLEN = 32;
   localparam int unsigned ILEN = 32;

   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [ILEN-1:0] INST_NOP         = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Prefetch buffer: DEPTH entries of {pc, inst}, with push, pop, flush and occupancy count.
module ifetch_fifo
   import riscv_defines::*;
#(
   parameter int unsigned DEPTH = 2,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               push,
   input  fetch_entry_t       push_data,
   input  logic               pop,
   output logic [CNT_W-1:0]   count,
   output fetch_entry_t       head
);

   fetch_entry_t           mem_q [DEPTH];
   logic [PTR_W-1:0]       head_q, tail_q;
   logic [CNT_W-1:0]       count_q;

   // DEPTH is a power of two, so pointers wrap naturally at their width.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else if (flush) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (push) tail_q <= tail_q + PTR_W'(1);
         if (pop)  head_q <= head_q + PTR_W'(1);
         count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) mem_q[tail_q] <= push_data;
   end

   assign count = count_q;
   assign head  = mem_q[head_q];

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: PC sequencing and redirect in front of a small prefetch buffer.
module ifetch_unit
   import riscv_defines::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int unsigned     DEPTH    = 2
) (
   input  logic            clk,
   input  logic            rst,
   output logic [XLEN-1:0] rom_addr_o,
   input  logic [ILEN-1:0] rom_inst_i,
   input  logic            jump_en_i,
   input  logic [XLEN-1:0] jump_addr_i,
   output logic            inst_valid_o,
   input  logic            inst_ready_i,
   output logic [ILEN-1:0] inst_o,
   output logic [XLEN-1:0] inst_addr_o
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [XLEN-1:0]  pc_q, pc_d;
   logic [CNT_W-1:0] count;
   logic             push, pop;
   fetch_entry_t     push_data, head;
   logic             unused_jump_lsb;

   assign unused_jump_lsb = ^jump_addr_i[1:0];

   always_comb begin
      pop       = inst_valid_o & inst_ready_i & ~jump_en_i;
      // Full buffer still accepts a push when the head leaves in the same cycle.
      push      = ~jump_en_i & ((count < CNT_W'(DEPTH)) | pop);
      push_data = '{pc: pc_q, inst: rom_inst_i};
   end

   always_comb begin
      pc_d = pc_q;
      if (jump_en_i) begin
         pc_d = {jump_addr_i[XLEN-1:2], 2'b00};
      end else if (push) begin
         pc_d = pc_q + 32'd4;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   ifetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (jump_en_i),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .count     (count),
      .head      (head)
   );

   always_comb begin
      rom_addr_o   = pc_q;
      inst_valid_o = (count != '0);
      inst_o       = inst_valid_o ? head.inst : INST_NOP;
      inst_addr_o  = inst_valid_o ? head.pc   : '0;
   end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed vector table on a DEPTH=2 instance, wrap and random
// scoreboard runs on a DEPTH=4 instance reset to 32'hFFFF_FFF8.
module tb_ifetch_unit;

   localparam logic [31:0] NOP     = 32'h0000_0013;
   localparam logic [31:0] ROM_KEY = 32'h5A3C_0000;
   localparam int unsigned NVEC    = 24;

   logic        clk;
   logic        rst, rst_w;

   logic [31:0] rom_addr, rom_inst, jaddr, inst, inst_addr;
   logic        jump, ready, valid;

   logic [31:0] rom_addr_w, rom_inst_w, jaddr_w, inst_w, inst_addr_w;
   logic        jump_w, ready_w, valid_w;

   int errors = 0;
   int checks = 0;

   assign rom_inst   = rom_addr;
   assign rom_inst_w = rom_addr_w ^ ROM_KEY;

   ifetch_unit #(
      .RESET_PC (32'h0000_0000),
      .DEPTH    (2)
   ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .rom_addr_o   (rom_addr),
      .rom_inst_i   (rom_inst),
      .jump_en_i    (jump),
      .jump_addr_i  (jaddr),
      .inst_valid_o (valid),
      .inst_ready_i (ready),
      .inst_o       (inst),
      .inst_addr_o  (inst_addr)
   );

   ifetch_unit #(
      .RESET_PC (32'hFFFF_FFF8),
      .DEPTH    (4)
   ) u_dut_w (
      .clk          (clk),
      .rst          (rst_w),
      .rom_addr_o   (rom_addr_w),
      .rom_inst_i   (rom_inst_w),
      .jump_en_i    (jump_w),
      .jump_addr_i  (jaddr_w),
      .inst_valid_o (valid_w),
      .inst_ready_i (ready_w),
      .inst_o       (inst_w),
      .inst_addr_o  (inst_addr_w)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst_n;
      logic        jump;
      logic [31:0] jaddr;
      logic        ready;
      logic        exp_valid;
      logic [31:0] exp_addr;
      logic [31:0] exp_rom;
   } vec_t;

   vec_t vecs [NVEC];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] m_pc;
   logic [63:0] sb [$];
   logic [31:0] exp_inst;
   logic [31:0] w_addr [4];
   logic [31:0] w_rom  [4];
   logic        m_pop, m_push;
   int          delivered;

   initial begin
      //              rst jmp jaddr          rdy v  exp_addr       exp_rom
      vecs[0]  = '{1'b0, 1'b0, 32'h0,     1'b1, 1'b0, 32'h0,   32'h0};
      vecs[1]  = '{1'b1, 1'b0, 32'h0,     1'b1, 1'b0, 32'h0,   32'h0};
      vecs[2]  = '{1'b1, 1'b0, 32'h0,     1'b1, 1'b1, 32'h0,   32'h4};
      vecs[3]  = '{1'b1, 1'b0, 32'h0,     1'b1, 1'b1, 32'h4,   32'h8};
      vecs[4]  = '{1'b1, 1'b0, 32'h0,     1'b1, 1'b1, 32'h8,   32'hC};
      vecs[5]  = '{1'b1, 1'b0, 32'h0,     1'b1, 1'b1, 32'hC,   32'h10};
      vecs[6]  = '{1'b1, 1'b0, 32'h0,     1'b0, 1'b1, 32'h10,  32'h14};
      // Two entries buffered; reset mid-stream must drop them at once.
      vecs[7]  = '{1'b0, 1'b0, 32'h0,     1'b0, 1'b0, 32'h0,   32'h0};
      vecs[8]  = '{1'b1, 1'b0, 32'h0,     1'b0, 1'b0, 32'h0,   32'h0};
      vecs[9]  = '{1'b1, 1'b0, 32'h0,     1'b0, 1'b1, 32'h0,   32'h4};
      vecs[10] = '{1'b1, 1'b0, 32'h0,     1'b0, 1'b1, 32'h0,   32'h8};
      vecs[11] = '{1'b1, 1'b0, 32'h0,     1'b0, 1'b1, 32'h0,   32'h8};
      vecs[12] = '{1'b1, 1'b0, 32'h0,     1'b0, 1'b1, 32'h0,   32'h8};
      vecs[13] = '{1'b1, 1'b0, 32'h0,     1'b1, 1'b1, 32'h0,   32'h8};
      vecs[14] = '{1'b1, 1'b0, 32'h0,     1'b1, 1'b1, 32'h4,   32'hC};
      vecs[15] = '{1'b1, 1'b0, 32'h0,     1'b0, 1'b1, 32'h8,   32'h10};
      vecs[16] = '{1'b1, 1'b1, 32'h103,   1'b0, 1'b1, 32'h8,   32'h10};
      vecs[17] = '{1'b1, 1'b0, 32'h0,     1'b0, 1'b0, 32'h0,   32'h100};
      vecs[18] = '{1'b1, 1'b0, 32'h0,     1'b0, 1'b1, 32'h100, 32'h104};
      vecs[19] = '{1'b1, 1'b1, 32'h200,   1'b0, 1'b1, 32'h100, 32'h108};
      vecs[20] = '{1'b1, 1'b1, 32'h301,   1'b0, 1'b0, 32'h0,   32'h200};
      vecs[21] = '{1'b1, 1'b0, 32'h0,     1'b0, 1'b0, 32'h0,   32'h300};
      vecs[22] = '{1'b1, 1'b0, 32'h0,     1'b1, 1'b1, 32'h300, 32'h304};
      vecs[23] = '{1'b1, 1'b0, 32'h0,     1'b1, 1'b1, 32'h304, 32'h308};

      w_addr = '{32'h0, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
      w_rom  = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};

      rst = 1'b0; jump = 1'b0; jaddr = '0; ready = 1'b0;
      rst_w = 1'b0; jump_w = 1'b0; jaddr_w = '0; ready_w = 1'b0;
      repeat (2) step();

      for (int i = 0; i < NVEC; i++) begin
         rst   = vecs[i].rst_n;
         jump  = vecs[i].jump;
         jaddr = vecs[i].jaddr;
         ready = vecs[i].ready;
         #1;
         exp_inst = vecs[i].exp_valid ? vecs[i].exp_addr : NOP;
         chk($sformatf("vec%0d rom_addr", i), rom_addr, vecs[i].exp_rom);
         chk($sformatf("vec%0d valid", i), {31'b0, valid}, {31'b0, vecs[i].exp_valid});
         chk($sformatf("vec%0d inst_addr", i), inst_addr, vecs[i].exp_addr);
         chk($sformatf("vec%0d inst", i), inst, exp_inst);
         step();
      end

      // PC wrap past 32'hFFFF_FFFC on the second instance.
      ready_w = 1'b1;
      rst_w   = 1'b1;
      for (int c = 0; c < 4; c++) begin
         #1;
         chk($sformatf("wrap%0d rom_addr", c), rom_addr_w, w_rom[c]);
         chk($sformatf("wrap%0d valid", c), {31'b0, valid_w}, {31'b0, (c != 0)});
         chk($sformatf("wrap%0d inst_addr", c), inst_addr_w, w_addr[c]);
         if (c != 0) chk($sformatf("wrap%0d inst", c), inst_w, w_addr[c] ^ ROM_KEY);
         step();
      end

      // Random ready/jump against a queue model of the buffer.
      rst_w = 1'b0;
      #1;
      chk("rand reset valid", {31'b0, valid_w}, 32'h0);
      step();
      rst_w = 1'b1;
      m_pc = 32'hFFFF_FFF8;
      sb.delete();
      delivered = 0;
      for (int c = 0; c < 800; c++) begin
         jump_w  = ($urandom_range(0, 9) == 0);
         jaddr_w = $urandom;
         if ($urandom_range(0, 3) == 0) jaddr_w = 32'hFFFF_FFF0 | ($urandom & 32'hF);
         ready_w = ($urandom_range(0, 9) < 6);
         #1;
         chk("rand rom_addr", rom_addr_w, m_pc);
         chk("rand valid", {31'b0, valid_w}, {31'b0, (sb.size() != 0)});
         if (sb.size() != 0) begin
            chk("rand inst_addr", inst_addr_w, sb[0][63:32]);
            chk("rand inst", inst_w, sb[0][31:0]);
         end else begin
            chk("rand empty inst_addr", inst_addr_w, 32'h0);
            chk("rand empty inst", inst_w, NOP);
         end
         if (jump_w) begin
            sb.delete();
            m_pc = {jaddr_w[31:2], 2'b00};
         end else begin
            m_pop  = (sb.size() != 0) && ready_w;
            m_push = (sb.size() < 4) || m_pop;
            if (m_pop) begin
               void'(sb.pop_front());
               delivered++;
            end
            if (m_push) begin
               sb.push_back({m_pc, m_pc ^ ROM_KEY});
               m_pc = m_pc + 32'd4;
            end
         end
         step();
      end
      chk("rand delivered some", {31'b0, (delivered > 100)}, 32'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
